text_console_writer: RTL and testbench
======================================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 80, characters per row.
REQ-002 Parameter ROWS, default 50, rows per screen.
REQ-003 Parameter CLEAR_ON_RESET, default 1, fills the screen with spaces after reset when 1.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 char_valid  in  1  input character present.
REQ-007 char_data  in  8  input character code; bit 7 is the inverse attribute and SHALL be stored unchanged.
REQ-008 char_ready  out  1  block accepts char_data this cycle.
REQ-009 vram_addr  out  12  video RAM address, row*COLS+col.
REQ-010 vram_wdata  out  8  video RAM write data.
REQ-011 vram_we  out  1  video RAM write strobe.
REQ-012 vram_rdata  in  8  video RAM read data, valid one cycle after vram_addr.
REQ-013 cursor_x  out  7  current column, 0..COLS-1.
REQ-014 cursor_y  out  6  current row, 0..ROWS-1.
REQ-015 busy  out  1  scroll or clear in progress.

Function
REQ-016 A character SHALL be accepted only on a clock edge where char_valid=1 and char_ready=1.
REQ-017 char_ready SHALL be 1 only in state IDLE; char_data SHALL be ignored when char_ready=0.
REQ-018 The state set SHALL be IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR.
REQ-019 A printable code (any code except 0x08, 0x0A, 0x0C, 0x0D) SHALL move IDLE->PUT.
- In PUT: vram_we=1, vram_addr=cursor_y*COLS+cursor_x, vram_wdata=code.
- Write occurs exactly one cycle after acceptance.
REQ-020 After a PUT write, cursor_x SHALL increment; at COLS-1 it SHALL wrap to 0 and a line feed SHALL follow (REQ-022).
REQ-021 0x0D (CR) SHALL set cursor_x=0 with no RAM access and return to IDLE.
REQ-022 0x0A (LF): if cursor_y<ROWS-1, cursor_y SHALL increment; if cursor_y=ROWS-1, the block SHALL enter SCROLL_RD at address 0 and cursor_y SHALL stay ROWS-1.
REQ-023 0x08 (BS) SHALL decrement cursor_x if it is >0, SHALL leave it unchanged at 0, and SHALL perform no RAM write.
REQ-024 0x0C (FF) SHALL enter CLEAR and set cursor to 0,0.
REQ-025 Scroll, for a = 0 .. COLS*(ROWS-1)-1:
- SCROLL_RD drives vram_addr=a+COLS, vram_we=0.
- SCROLL_WR drives vram_addr=a, vram_wdata=vram_rdata, vram_we=1.
- Cost is 2 cycles per byte.
REQ-026 After the last row copy, the block SHALL write 0x20 to each of the COLS cells of row ROWS-1, one per cycle, then return to IDLE.
REQ-027 CLEAR SHALL write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then return to IDLE.
REQ-028 busy SHALL be 1 exactly while the state is SCROLL_RD, SCROLL_WR or CLEAR.
REQ-029 vram_we SHALL be 0 in every cycle not listed in REQ-019, REQ-025, REQ-026 or REQ-027.
REQ-030 All address arithmetic SHALL be 12-bit unsigned; the maximum address is 3999 at default parameters.
REQ-031 Simultaneous wrap and LF: a printable at column COLS-1 on row ROWS-1 SHALL write its cell, then scroll, leaving the cursor at 0,ROWS-1.

Reset
REQ-032 While rst=1, outputs SHALL be: char_ready=0, vram_we=0, vram_addr=0, vram_wdata=0, cursor 0,0, busy=0, state IDLE.
REQ-033 After rst falls with CLEAR_ON_RESET=1, the block SHALL enter CLEAR on the first clock edge; with CLEAR_ON_RESET=0, char_ready SHALL rise on the first clock edge.
REQ-034 rst asserted mid-scroll or mid-clear SHALL abort the operation immediately with no further writes.

Structure
REQ-035 A shared package text_console_pkg SHALL hold COLS, ROWS, the control-code constants (BS, LF, FF, CR, SPACE) and the state enumeration.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 The RAM SHALL be external and dual-port; the text display adapter reads the second port.

Verification
REQ-038 Reset with CLEAR_ON_RESET=1 -> exactly 4000 writes of 0x20 to addresses 0..3999, then char_ready=1, cursor 0,0.
REQ-039 Send 'H','i' -> 0x48 written to address 0 and 0x69 to address 1, each one cycle after acceptance; cursor_x=2.
REQ-040 Send 0x0D, 0x0A, then 0x41 from cursor 5,3 -> 0x41 written to address 320; final cursor 1,4.
REQ-041 Preload row 1 with 0x31 and row 49 with 0x39, cursor at row 49, send LF -> row 0 reads 0x31, row 48 reads 0x39, row 49 reads 0x20, busy high for 7920 cycles.
REQ-042 Send 80 printables on row 49 -> 80th character written to address 3999, scroll follows, final cursor 0,49.
REQ-043 Assert rst 100 cycles into a scroll -> vram_we low from the reset edge onward; after reset, clear runs from address 0.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants for the text console: default screen geometry,
// control codes recognised in the character stream, and writer states.
package text_console_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 50;

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    CLEAR
  } state_t;

endpackage

// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into writes on an external
// dual-port video RAM, keeping a cursor and handling CR, LF, BS, FF,
// line wrap, scrolling and screen clear.
module text_console_writer #(
  parameter int COLS           = text_console_pkg::COLS,
  parameter int ROWS           = text_console_pkg::ROWS,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        busy
);
  import text_console_pkg::*;

  localparam logic [6:0]  LAST_X    = 7'(COLS - 1);
  localparam logic [5:0]  LAST_Y    = 6'(ROWS - 1);
  localparam logic [11:0] ROW_W     = 12'(COLS);
  // Last destination address of the row-copy phase of a scroll.
  localparam logic [11:0] LAST_DST  = 12'(COLS * (ROWS - 1) - 1);
  // First cell of the bottom row, blanked after the copy.
  localparam logic [11:0] TAIL_BASE = 12'(COLS * (ROWS - 1));
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  state_t      r_state;
  logic        r_ready;
  logic        r_we;
  logic        r_busy;
  logic        r_init;
  logic [11:0] r_addr;
  logic [7:0]  r_wdata;
  logic [6:0]  r_cx;
  logic [5:0]  r_cy;
  logic [7:0]  w_wdata;

  function automatic logic [11:0] cell_addr(input logic [5:0] y, input logic [6:0] x);
    return (12'(y) * ROW_W) + 12'(x);
  endfunction

  // Writer FSM: cursor tracking, character put, scroll copy and space fill.
  // r_init marks the first edge after reset so the optional clear can start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_init  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_init <= 1'b0;
          if (r_init) begin
            if (CLEAR_ON_RESET != 0) begin
              r_state <= CLEAR;
              r_addr  <= '0;
              r_wdata <= SPACE;
              r_we    <= 1'b1;
              r_busy  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_ready <= 1'b1;
            end
          end else if (char_valid && r_ready) begin
            case (char_data)
              CR: r_cx <= '0;
              BS: begin
                if (r_cx != 7'd0) r_cx <= r_cx - 7'd1;
              end
              LF: begin
                if (r_cy != LAST_Y) begin
                  r_cy <= r_cy + 6'd1;
                end else begin
                  r_state <= SCROLL_RD;
                  r_addr  <= ROW_W;
                  r_we    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                end
              end
              FF: begin
                r_cx    <= '0;
                r_cy    <= '0;
                r_state <= CLEAR;
                r_addr  <= '0;
                r_wdata <= SPACE;
                r_we    <= 1'b1;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
              end
              default: begin
                r_state <= PUT;
                r_addr  <= cell_addr(r_cy, r_cx);
                r_wdata <= char_data;
                r_we    <= 1'b1;
                r_ready <= 1'b0;
              end
            endcase
          end
        end
        PUT: begin
          r_we <= 1'b0;
          if (r_cx == LAST_X) begin
            r_cx <= '0;
            if (r_cy != LAST_Y) begin
              r_cy    <= r_cy + 6'd1;
              r_state <= IDLE;
              r_ready <= 1'b1;
            end else begin
              r_state <= SCROLL_RD;
              r_addr  <= ROW_W;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cx    <= r_cx + 7'd1;
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        SCROLL_RD: begin
          // Source byte appears on vram_rdata during the following write cycle.
          r_state <= SCROLL_WR;
          r_addr  <= r_addr - ROW_W;
          r_we    <= 1'b1;
        end
        SCROLL_WR: begin
          if (r_addr == LAST_DST) begin
            r_state <= CLEAR;
            r_addr  <= TAIL_BASE;
            r_wdata <= SPACE;
            r_we    <= 1'b1;
          end else begin
            r_state <= SCROLL_RD;
            r_addr  <= r_addr + ROW_W + 12'd1;
            r_we    <= 1'b0;
          end
        end
        CLEAR: begin
          // Shared by full clear and the bottom-row blank after a scroll.
          if (r_addr == LAST_ADDR) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_addr <= r_addr + 12'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // During a scroll write the RAM read data passes straight through.
  always_comb begin
    w_wdata = r_wdata;
    if (r_state == SCROLL_WR) w_wdata = vram_rdata;
  end

  assign char_ready = r_ready;
  assign vram_addr  = r_addr;
  assign vram_wdata = w_wdata;
  assign vram_we    = r_we;
  assign cursor_x   = r_cx;
  assign cursor_y   = r_cy;
  assign busy       = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: video RAM model, screen-level reference
// model, table vectors, directed corner sequences and random traffic.
module tb_text_console_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 50;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_rdata(vram_rdata), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .busy(busy)
  );

  // Video RAM: synchronous write, read data one cycle after address; bench preload port.
  logic [7:0]  mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_data;
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    vram_rdata <= mem[vram_addr];
  end

  // Reference screen model.
  logic [7:0] model [0:NCELL-1];
  int mx, my, scrolls;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  code;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [6:0]  exp_x;
    logic [5:0]  exp_y;
  } vec_t;
  vec_t tbl [12];

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no response expected completion", name);
    finish_run();
  endtask

  function automatic bit is_ctrl(input logic [7:0] c);
    return (c == 8'h08) || (c == 8'h0A) || (c == 8'h0C) || (c == 8'h0D);
  endfunction

  task automatic model_blank();
    for (int i = 0; i < NCELL; i++) model[i] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_lf();
    if (my < ROWS - 1) begin
      my++;
    end else begin
      for (int i = 0; i < NCELL - COLS; i++) model[i] = model[i + COLS];
      for (int i = NCELL - COLS; i < NCELL; i++) model[i] = 8'h20;
      scrolls++;
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c == 8'h0D) mx = 0;
    else if (c == 8'h08) begin
      if (mx > 0) mx--;
    end else if (c == 8'h0A) model_lf();
    else if (c == 8'h0C) model_blank();
    else begin
      model[my * COLS + mx] = c;
      if (mx == COLS - 1) begin
        mx = 0;
        model_lf();
      end else begin
        mx++;
      end
    end
  endtask

  task automatic compare_screen(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < NCELL; i++)
      if (mem[i] !== model[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: cell %0d got 0x%0h expected 0x%0h", name, bad, mem[bad], model[bad]);
    end
  endtask

  task automatic send_char(input logic [7:0] code, input bit wait_done,
                           output logic s_we, output logic [11:0] s_addr,
                           output logic [7:0] s_wdata, output int busy_cycles);
    int w;
    int ea;
    w = 0;
    @(negedge clk);
    while (!char_ready && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (!char_ready) timeout_fail("ready_wait");
    ea = my * COLS + mx;
    char_data  = code;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    s_we    = vram_we;
    s_addr  = vram_addr;
    s_wdata = vram_wdata;
    if (!is_ctrl(code)) begin
      check("put_we", int'(s_we), 1);
      check("put_addr", int'(s_addr), ea);
      check("put_data", int'(s_wdata), int'(code));
    end else if (code == 8'h0C) begin
      check("ff_we", int'(s_we), 1);
      check("ff_addr", int'(s_addr), 0);
    end else begin
      check("ctrl_no_we", int'(s_we), 0);
    end
    model_char(code);
    busy_cycles = 0;
    if (wait_done) begin
      w = 0;
      @(negedge clk);
      while ((!char_ready || busy) && w < 20000) begin
        if (busy) busy_cycles++;
        @(negedge clk);
        w++;
      end
      if (!char_ready || busy) timeout_fail("done_wait");
      check("cursor_x", int'(cursor_x), mx);
      check("cursor_y", int'(cursor_y), my);
    end
  endtask

  task automatic send(input logic [7:0] c);
    logic        a;
    logic [11:0] b;
    logic [7:0]  d;
    int          e;
    send_char(c, 1'b1, a, b, d, e);
  endtask

  task automatic bd_fill(input int base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = 12'(base + i);
      bd_data = v;
      model[base + i] = v;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Releases reset and follows the power-on clear, holding a stray character
  // on the input the whole time to show it is ignored while not ready.
  task automatic release_and_check_clear();
    int n, first, w;
    bit order_ok;
    @(negedge clk);
    rst = 1'b0;
    char_valid = 1'b1;
    char_data  = 8'h58;
    n = 0; first = -1; w = 0; order_ok = 1'b1;
    while (w < 6000) begin
      @(posedge clk);
      #1;
      if (vram_we) begin
        if (first < 0) first = w;
        if (vram_addr != 12'(n) || vram_wdata != 8'h20) order_ok = 1'b0;
        n++;
      end
      w++;
      if (char_ready) break;
    end
    char_valid = 1'b0;
    if (!char_ready) timeout_fail("clear_ready");
    check("clear_first_cycle", first, 0);
    check("clear_count", n, NCELL);
    check("clear_order", int'(order_ok), 1);
    check("clear_cursor_x", int'(cursor_x), 0);
    check("clear_cursor_y", int'(cursor_y), 0);
    check("clear_busy", int'(busy), 0);
    model_blank();
    compare_screen("clear_screen");
  endtask

  initial begin
    #(10 * 98000);
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    logic        s_we;
    logic [11:0] s_addr;
    logic [7:0]  s_wdata;
    int          bc;
    bit          ok1, ok9, ok20;
    logic [7:0]  c;
    int          r;

    rst = 1'b1; char_valid = 1'b0; char_data = 8'h00;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; scrolls = 0;
    mx = 0; my = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(char_ready), 0);
    check("rst_we", int'(vram_we), 0);
    check("rst_addr", int'(vram_addr), 0);
    check("rst_wdata", int'(vram_wdata), 0);
    check("rst_cx", int'(cursor_x), 0);
    check("rst_cy", int'(cursor_y), 0);
    check("rst_busy", int'(busy), 0);
    release_and_check_clear();

    // Table vectors from cursor 0,0
    tbl[0]  = '{8'h48, 1'b1, 12'd0,   7'd1, 6'd0};
    tbl[1]  = '{8'h69, 1'b1, 12'd1,   7'd2, 6'd0};
    tbl[2]  = '{8'h08, 1'b0, 12'd0,   7'd1, 6'd0};
    tbl[3]  = '{8'h08, 1'b0, 12'd0,   7'd0, 6'd0};
    tbl[4]  = '{8'h08, 1'b0, 12'd0,   7'd0, 6'd0};
    tbl[5]  = '{8'h0A, 1'b0, 12'd0,   7'd0, 6'd1};
    tbl[6]  = '{8'hC1, 1'b1, 12'd80,  7'd1, 6'd1};
    tbl[7]  = '{8'h21, 1'b1, 12'd81,  7'd2, 6'd1};
    tbl[8]  = '{8'h0D, 1'b0, 12'd0,   7'd0, 6'd1};
    tbl[9]  = '{8'h7E, 1'b1, 12'd80,  7'd1, 6'd1};
    tbl[10] = '{8'h0A, 1'b0, 12'd0,   7'd1, 6'd2};
    tbl[11] = '{8'h20, 1'b1, 12'd161, 7'd2, 6'd2};
    for (int i = 0; i < 12; i++) begin
      send_char(tbl[i].code, 1'b1, s_we, s_addr, s_wdata, bc);
      check($sformatf("tbl%0d_we", i), int'(s_we), int'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        check($sformatf("tbl%0d_addr", i), int'(s_addr), int'(tbl[i].exp_addr));
        check($sformatf("tbl%0d_data", i), int'(s_wdata), int'(tbl[i].code));
      end
      check($sformatf("tbl%0d_x", i), int'(cursor_x), int'(tbl[i].exp_x));
      check($sformatf("tbl%0d_y", i), int'(cursor_y), int'(tbl[i].exp_y));
    end
    check("hi_mem0", int'(mem[0]), 8'h48);
    check("hi_mem1", int'(mem[1]), 8'h69);
    check("inv_mem80", int'(mem[80]), 8'h7E);
    compare_screen("table_screen");

    // CR, LF, 'A' from cursor 5,3
    send(8'h0C);
    repeat (3) send(8'h0A);
    repeat (5) send(8'h20);
    check("pos53_x", int'(cursor_x), 5);
    check("pos53_y", int'(cursor_y), 3);
    send(8'h0D);
    send(8'h0A);
    send_char(8'h41, 1'b1, s_we, s_addr, s_wdata, bc);
    check("crlf_addr", int'(s_addr), 320);
    check("crlf_mem", int'(mem[320]), 8'h41);
    check("crlf_x", int'(cursor_x), 1);
    check("crlf_y", int'(cursor_y), 4);

    // Scroll with preloaded rows 1 and 49
    send(8'h0C);
    repeat (49) send(8'h0A);
    bd_fill(80, 80, 8'h31);
    bd_fill(3920, 80, 8'h39);
    send_char(8'h0A, 1'b1, s_we, s_addr, s_wdata, bc);
    check("scroll_busy_cycles", bc, 7920);
    ok1 = 1'b1; ok9 = 1'b1; ok20 = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      if (mem[i] != 8'h31) ok1 = 1'b0;
      if (mem[48 * COLS + i] != 8'h39) ok9 = 1'b0;
      if (mem[49 * COLS + i] != 8'h20) ok20 = 1'b0;
    end
    check("scroll_row0", int'(ok1), 1);
    check("scroll_row48", int'(ok9), 1);
    check("scroll_row49", int'(ok20), 1);
    check("scroll_cy", int'(cursor_y), 49);
    compare_screen("scroll_screen");

    // 80 printables on the bottom row: write at 3999, then scroll
    for (int i = 0; i < COLS; i++) begin
      send_char(8'(8'h41 + (i % 26)), 1'b1, s_we, s_addr, s_wdata, bc);
      if (i == COLS - 1) begin
        check("wrap_last_addr", int'(s_addr), 3999);
        check("wrap_busy_cycles", bc, 7920);
      end
    end
    check("wrap_x", int'(cursor_x), 0);
    check("wrap_y", int'(cursor_y), 49);
    compare_screen("wrap_screen");

    // Random traffic near the bottom of the screen
    send(8'h0C);
    repeat (45) send(8'h0A);
    scrolls = 0;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 199);
      if (r < 16) c = 8'h0A;
      else if (r < 28) c = 8'h0D;
      else if (r < 36) c = 8'h08;
      else if (r < 37) c = 8'h0C;
      else begin
        c = 8'($urandom);
        if (is_ctrl(c)) c = 8'h2A;
      end
      if (my == ROWS - 1 && scrolls >= 2) begin
        if (c == 8'h0A) c = 8'h0D;
        else if (!is_ctrl(c) && mx == COLS - 1) c = 8'h08;
      end
      send(c);
    end
    compare_screen("random_screen");

    // Reset 100 cycles into a scroll
    send(8'h0C);
    repeat (49) send(8'h0A);
    send_char(8'h0A, 1'b0, s_we, s_addr, s_wdata, bc);
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_we", int'(vram_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(char_ready), 0);
    check("abort_addr", int'(vram_addr), 0);
    check("abort_cy", int'(cursor_y), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_hold_we", int'(vram_we), 0);
    end
    release_and_check_clear();

    finish_run();
  end

endmodule
